// File: rtl/scalable_leaf_router_if.sv
// Purpose: bundles the NI and spine data/valid/ready links of one leaf router.
// Ports (signals):
//   gpu_in_data/valid/ready     NI -> router flit link
//   gpu_out_data/valid/ready    router -> NI flit link
//   spine_in_data/valid/ready   spines -> router, spine i in data[i*DWIDTH +: DWIDTH]
//   spine_out_data/valid/ready  router -> spines, same lane packing
// Modports: slave = router side, master = environment side.
interface scalable_leaf_router_if #(
  parameter int unsigned DWIDTH     = 16,
  parameter int unsigned NUM_SPINES = 4
);

  logic [DWIDTH-1:0]            gpu_in_data;
  logic                         gpu_in_valid;
  logic                         gpu_in_ready;

  logic [DWIDTH-1:0]            gpu_out_data;
  logic                         gpu_out_valid;
  logic                         gpu_out_ready;

  logic [NUM_SPINES*DWIDTH-1:0] spine_in_data;
  logic [NUM_SPINES-1:0]        spine_in_valid;
  logic [NUM_SPINES-1:0]        spine_in_ready;

  logic [NUM_SPINES*DWIDTH-1:0] spine_out_data;
  logic [NUM_SPINES-1:0]        spine_out_valid;
  logic [NUM_SPINES-1:0]        spine_out_ready;

  modport slave (
    input  gpu_in_data, gpu_in_valid,
    output gpu_in_ready,
    output gpu_out_data, gpu_out_valid,
    input  gpu_out_ready,
    input  spine_in_data, spine_in_valid,
    output spine_in_ready,
    output spine_out_data, spine_out_valid,
    input  spine_out_ready
  );

  modport master (
    output gpu_in_data, gpu_in_valid,
    input  gpu_in_ready,
    input  gpu_out_data, gpu_out_valid,
    output gpu_out_ready,
    output spine_in_data, spine_in_valid,
    input  spine_in_ready,
    input  spine_out_data, spine_out_valid,
    output spine_out_ready
  );

endinterface

// File: rtl/scalable_leaf_router.sv
// Purpose: leaf router for one GPU tile. The NI input FIFO is steered to the
//   spine selected by the low destination bits; spine input FIFOs carrying
//   local flits are merged onto the NI output by a round-robin arbiter, and
//   misaddressed spine flits are dropped and counted (saturating).
// Ports:
//   clk, reset     clock and synchronous active-high reset
//   bus            scalable_leaf_router_if.slave (NI and spine links)
//   fifo_full      bit 0 = NI FIFO full, bit i+1 = spine i FIFO full
//   fifo_empty     same mapping, empty flags
//   drop_count     dropped misaddressed spine flits, saturating at 16'hFFFF
//   current_grant  last spine granted to the NI output
module scalable_leaf_router #(
  parameter int unsigned DWIDTH     = 16,
  parameter int unsigned NUM_SPINES = 4,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [1:0]  ROUTER_ID  = 2'd2,
  parameter logic [3:0]  GROUP_ID   = 4'b0101,
  localparam int unsigned SW        = (NUM_SPINES > 1) ? $clog2(NUM_SPINES) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  scalable_leaf_router_if.slave   bus,
  output logic [NUM_SPINES:0]     fifo_full,
  output logic [NUM_SPINES:0]     fifo_empty,
  output logic [15:0]             drop_count,
  output logic [SW-1:0]           current_grant
);

  localparam int unsigned NF         = NUM_SPINES + 1;
  localparam int unsigned AW         = $clog2(FIFO_DEPTH);
  localparam int unsigned CW         = AW + 1;
  localparam logic [5:0]  LOCAL_ADDR = {GROUP_ID, ROUTER_ID};

  // FIFO index 0 is the NI input, index i+1 is spine i
  logic [DWIDTH-1:0]                    w_in_data [NF];
  logic [NF-1:0]                        w_in_valid;
  logic [NF-1:0]                        w_full;
  logic [NF-1:0]                        w_empty;
  logic [NF-1:0]                        w_pop;
  logic [DWIDTH-1:0]                    w_head [NF];
  logic [NUM_SPINES-1:0][DWIDTH-1:0]    w_sp_head;

  logic [SW-1:0]                        w_ni_dest;
  logic                                 w_ni_pop;
  logic [NUM_SPINES-1:0]                w_sp_free;
  logic [NUM_SPINES-1:0]                w_sp_load;
  logic [NUM_SPINES-1:0]                w_sp_local;
  logic [NUM_SPINES-1:0]                w_sp_drop;

  logic                                 w_gpu_free;
  logic                                 w_gpu_load;
  logic                                 w_found;
  logic [SW-1:0]                        w_win;
  logic [SW-1:0]                        w_idx;
  logic [16:0]                          w_drop_sum;

  logic                                 r_gpu_valid;
  logic [DWIDTH-1:0]                    r_gpu_data;
  logic [SW-1:0]                        r_grant;
  logic [15:0]                          r_drop_count;

  // Input lane unpacking
  assign w_in_data[0]  = bus.gpu_in_data;
  assign w_in_valid[0] = bus.gpu_in_valid;

  for (genvar i = 0; i < NUM_SPINES; i++) begin : g_spine_in
    assign w_in_data[i+1]  = bus.spine_in_data[i*DWIDTH +: DWIDTH];
    assign w_in_valid[i+1] = bus.spine_in_valid[i];
  end

  // Input FIFOs; full/empty are registered so every *_in_ready is a flop output
  for (genvar g = 0; g < NF; g++) begin : g_fifo
    logic [DWIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic              r_full;
    logic              r_empty;
    logic              w_push;
    logic [CW-1:0]     w_count_nxt;

    assign w_push      = w_in_valid[g] && !r_full;
    assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop[g]);

    always_ff @(posedge clk) begin
      if (reset) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
        r_full   <= 1'b0;
        r_empty  <= 1'b1;
      end else begin
        if (w_push)   r_wr_ptr <= r_wr_ptr + AW'(1);
        if (w_pop[g]) r_rd_ptr <= r_rd_ptr + AW'(1);
        r_count <= w_count_nxt;
        r_full  <= (w_count_nxt == CW'(FIFO_DEPTH));
        r_empty <= (w_count_nxt == CW'(0));
      end
    end

    // Storage needs no reset: pointers alone define the contents
    always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= w_in_data[g];
    end

    assign w_head[g]  = r_mem[r_rd_ptr];
    assign w_full[g]  = r_full;
    assign w_empty[g] = r_empty;
  end

  // NI head steering: low destination bits pick the spine, head-of-line blocking
  assign w_ni_dest = (NUM_SPINES == 1) ? SW'(0) : SW'(w_head[0][DWIDTH-1 -: 6]);
  assign w_ni_pop  = !w_empty[0] && w_sp_free[w_ni_dest];
  assign w_pop[0]  = w_ni_pop;

  // Per-spine head classification, pops and one-entry output registers
  for (genvar i = 0; i < NUM_SPINES; i++) begin : g_sp_ctl
    logic              r_out_valid;
    logic [DWIDTH-1:0] r_out_data;

    assign w_sp_head[i]  = w_head[i+1];
    assign w_sp_local[i] = !w_empty[i+1] && (w_head[i+1][DWIDTH-1 -: 6] == LOCAL_ADDR);
    assign w_sp_drop[i]  = !w_empty[i+1] && (w_head[i+1][DWIDTH-1 -: 6] != LOCAL_ADDR);
    assign w_sp_free[i]  = !r_out_valid || bus.spine_out_ready[i];
    assign w_sp_load[i]  = w_ni_pop && (w_ni_dest == SW'(i));
    // A spine head leaves either as a drop or as the arbitration winner
    assign w_pop[i+1]    = w_sp_drop[i] || (w_gpu_load && (w_win == SW'(i)));

    always_ff @(posedge clk) begin
      if (reset) begin
        r_out_valid <= 1'b0;
        r_out_data  <= '0;
      end else if (w_sp_load[i]) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_head[0];
      end else if (bus.spine_out_ready[i]) begin
        r_out_valid <= 1'b0;
      end
    end

    assign bus.spine_out_valid[i]                 = r_out_valid;
    assign bus.spine_out_data[i*DWIDTH +: DWIDTH] = r_out_data;
  end

  // Round-robin search starting one past the last grant
  always_comb begin
    w_found = 1'b0;
    w_win   = r_grant;
    w_idx   = '0;
    for (int unsigned k = 1; k <= NUM_SPINES; k++) begin
      w_idx = SW'((32'(r_grant) + k) % NUM_SPINES);
      if (!w_found && w_sp_local[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  assign w_gpu_free = !r_gpu_valid || bus.gpu_out_ready;
  assign w_gpu_load = w_gpu_free && w_found;

  // Drops from several spines in one cycle add together before saturation
  assign w_drop_sum = {1'b0, r_drop_count} + 17'($countones(w_sp_drop));

  // NI output register, grant pointer and drop counter
  always_ff @(posedge clk) begin
    if (reset) begin
      r_gpu_valid  <= 1'b0;
      r_gpu_data   <= '0;
      r_grant      <= SW'(NUM_SPINES - 1);
      r_drop_count <= '0;
    end else begin
      if (w_gpu_load) begin
        r_gpu_valid <= 1'b1;
        r_gpu_data  <= w_sp_head[w_win];
        r_grant     <= w_win;
      end else if (bus.gpu_out_ready) begin
        r_gpu_valid <= 1'b0;
      end
      r_drop_count <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
    end
  end

  // Output mapping
  assign bus.gpu_in_ready   = !w_full[0];
  assign bus.spine_in_ready = ~w_full[NF-1:1];
  assign bus.gpu_out_valid  = r_gpu_valid;
  assign bus.gpu_out_data   = r_gpu_data;
  assign fifo_full          = w_full;
  assign fifo_empty         = w_empty;
  assign drop_count         = r_drop_count;
  assign current_grant      = r_grant;

endmodule
